// File: rtl/aes_tx_serializer_if.sv
// aes_tx_serializer_if: block-enqueue side and byte-stream side of the AES TX serializer.
// master = producer/consumer environment, slave = the serializer itself.
interface aes_tx_serializer_if;
  logic [127:0] din;
  logic         write_en;
  logic         full;
  logic         empty;
  logic         overflow;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;

  modport master (
    output din, write_en, tx_ready,
    input  full, empty, overflow, tx_data, tx_valid, busy
  );

  modport slave (
    input  din, write_en, tx_ready,
    output full, empty, overflow, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/aes_tx_serializer.sv
// aes_tx_serializer: DEPTH-entry FIFO of 128-bit AES blocks, drained MSB byte
// first onto a byte valid/ready stream for the UART TX.
// Optional feature macro: AES_TX_FRAME_EN -- prefix each block with sync byte 8'hA5.
module aes_tx_serializer #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  aes_tx_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef AES_TX_FRAME_EN
  // Header byte rides in the top of a wider shift register so the output
  // tap is always the top byte.
  localparam int SW = 136;
  localparam int CW = 5;
`else
  localparam int SW = 128;
  localparam int CW = 4;
`endif
  localparam logic [CW-1:0] LAST = CW'(SW/8 - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t            state, state_nxt;
  logic [127:0]      mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  logic [SW-1:0]     shreg;
  logic [CW-1:0]     cnt;
  logic              wr, pop, hs;

  // A write while full is dropped even if a pop happens the same cycle,
  // because full is the registered flag from the previous edge.
  assign wr  = bus.write_en && !bus.full;
  assign pop = (state == LOAD);
  assign hs  = (state == SEND) && bus.tx_ready;

  // Outputs derive only from registers: no tx_ready -> tx_valid/tx_data path.
  assign bus.tx_valid = (state == SEND);
  assign bus.busy     = (state != IDLE);
  assign bus.tx_data  = shreg[SW-1 -: 8];

  // Occupancy after this edge's write/pop.
  always_comb begin
    count_nxt = count;
    case ({wr, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array; stale contents are harmless once the pointers reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.din;
  end

  // Pointers, count and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.full     <= 1'b0;
      bus.empty    <= 1'b1;
      bus.overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      bus.full  <= (count_nxt == FULL_CNT);
      bus.empty <= (count_nxt == '0);
      if (bus.write_en && bus.full) bus.overflow <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one LOAD bubble between blocks, chained while the FIFO has data.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.empty) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (hs && cnt == LAST) state_nxt = bus.empty ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and byte counter: load on LOAD, shift on each handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (pop) begin
`ifdef AES_TX_FRAME_EN
      shreg <= {8'hA5, mem[rd_ptr]};
`else
      shreg <= mem[rd_ptr];
`endif
      cnt   <= '0;
    end else if (hs) begin
      shreg <= shreg << 8;
      cnt   <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_aes_tx_serializer.sv
// tb_aes_tx_serializer: directed scenarios for the AES TX block serializer.
module tb_aes_tx_serializer;
  localparam int DEPTH = 4;
`ifdef AES_TX_FRAME_EN
  localparam int NB  = 17;
  localparam int HDR = 1;
`else
  localparam int NB  = 16;
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] rx[$];

  aes_tx_serializer_if bus();

  aes_tx_serializer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Block k carries bytes k*16+0 .. k*16+15, MSB byte first.
  function automatic logic [127:0] mk_block(input int k);
    logic [127:0] b;
    b = '0;
    for (int j = 0; j < 16; j++) b[127-8*j -: 8] = 8'(k*16 + j);
    return b;
  endfunction

  // i-th handshake byte of block k, including the sync byte when framed.
  function automatic logic [7:0] exp_byte(input int k, input int i);
    if (HDR == 1 && i == 0) return 8'hA5;
    return 8'(k*16 + i - HDR);
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx.size()) return rx[i];
    return 8'hxx;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts bytes with tx_ready=1 until n are seen or the budget runs out.
  task automatic collect(input int n, input int budget, output int cycles);
    cycles = 0;
    bus.tx_ready = 1'b1;
    while (rx.size() < n && cycles < budget) begin
      if (bus.tx_valid) rx.push_back(bus.tx_data);
      tick;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick;
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", bus.tx_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    reset = 1'b1;
    tick;
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL rst_full got=%b exp=0", bus.full); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL rst_empty got=%b exp=1", bus.empty); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow); end
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rst_valid2 got=%b exp=0", bus.tx_valid); end
    tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL rst_data got=%h exp=00", bus.tx_data); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy2 got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single_block;
    int cyc;
    rx.delete();
    bus.tx_ready = 1'b1;
    bus.din = mk_block(0);
    bus.write_en = 1'b1;
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL single_n0_valid got=%b exp=0", bus.tx_valid); end
    tick;
    bus.write_en = 1'b0;
    tests++; if (bus.empty !== 1'b0) begin fails++; $display("FAIL single_n1_empty got=%b exp=0", bus.empty); end
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL single_n1_valid got=%b exp=0", bus.tx_valid); end
    tick;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_n2_busy got=%b exp=1", bus.busy); end
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL single_n2_valid got=%b exp=0", bus.tx_valid); end
    tick;
    tests++; if (bus.tx_valid !== 1'b1) begin fails++; $display("FAIL single_n3_valid got=%b exp=1", bus.tx_valid); end
    collect(NB, NB + 10, cyc);
    tests++; if (cyc !== NB) begin fails++; $display("FAIL single_cycles got=%0d exp=%0d", cyc, NB); end
    for (int i = 0; i < NB; i++) begin
      tests++;
      if (rx_at(i) !== exp_byte(0, i)) begin fails++; $display("FAIL single_byte%0d got=%h exp=%h", i, rx_at(i), exp_byte(0, i)); end
    end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_end_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL single_end_empty got=%b exp=1", bus.empty); end
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL single_end_valid got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_backpressure;
    int g;
    bit stalled;
    int stall_idx;
    g = 0;
    stalled = 1'b0;
    stall_idx = HDR + 7;
    rx.delete();
    bus.din = mk_block(0);
    bus.write_en = 1'b1;
    tick;
    bus.write_en = 1'b0;
    bus.tx_ready = 1'b1;
    while (rx.size() < NB && g < 100) begin
      if (bus.tx_valid && rx.size() == stall_idx && !stalled) begin
        stalled = 1'b1;
        bus.tx_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tests++; if (bus.tx_data !== 8'h07) begin fails++; $display("FAIL bp_hold_data%0d got=%h exp=07", s, bus.tx_data); end
          tests++; if (bus.tx_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid%0d got=%b exp=1", s, bus.tx_valid); end
          tick;
          g++;
        end
        bus.tx_ready = 1'b1;
      end
      if (bus.tx_valid) rx.push_back(bus.tx_data);
      tick;
      g++;
    end
    tests++; if (stalled !== 1'b1) begin fails++; $display("FAIL bp_stall_reached got=%b exp=1", stalled); end
    tests++; if (rx_at(stall_idx + 1) !== 8'h08) begin fails++; $display("FAIL bp_after got=%h exp=08", rx_at(stall_idx + 1)); end
    for (int i = 0; i < NB; i++) begin
      tests++;
      if (rx_at(i) !== exp_byte(0, i)) begin fails++; $display("FAIL bp_byte%0d got=%h exp=%h", i, rx_at(i), exp_byte(0, i)); end
    end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL bp_end_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_overflow;
    int cyc;
    int vcnt;
    rx.delete();
    bus.tx_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus.din = mk_block(k);
      bus.write_en = 1'b1;
      if (k == 5) begin
        tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL ovf_prefull got=%b exp=0", bus.full); end
      end
      if (k == 6) begin
        tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL ovf_full got=%b exp=1", bus.full); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_pre got=%b exp=0", bus.overflow); end
      end
      tick;
    end
    bus.write_en = 1'b0;
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
    tests++; if (bus.tx_data !== exp_byte(1, 0)) begin fails++; $display("FAIL ovf_head got=%h exp=%h", bus.tx_data, exp_byte(1, 0)); end
    tick;
    tick;
    tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    collect(5*NB, 5*(NB+1) + 20, cyc);
    tests++; if (rx.size() !== 5*NB) begin fails++; $display("FAIL ovf_count got=%0d exp=%0d", rx.size(), 5*NB); end
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < NB; i++) begin
        tests++;
        if (rx_at(b*NB + i) !== exp_byte(b + 1, i)) begin fails++; $display("FAIL ovf_blk%0d_byte%0d got=%h exp=%h", b, i, rx_at(b*NB + i), exp_byte(b + 1, i)); end
      end
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.tx_valid) vcnt++;
      tick;
    end
    tests++; if (vcnt !== 0) begin fails++; $display("FAIL ovf_dropped_seen got=%0d exp=0", vcnt); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL ovf_end_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_reset_mid;
    int g;
    int vcnt;
    g = 0;
    rx.delete();
    bus.tx_ready = 1'b1;
    bus.din = mk_block(0);
    bus.write_en = 1'b1;
    tick;
    bus.din = mk_block(1);
    tick;
    bus.write_en = 1'b0;
    while (rx.size() < HDR + 6 && g < 40) begin
      if (bus.tx_valid) rx.push_back(bus.tx_data);
      tick;
      g++;
    end
    tests++; if (rx_at(HDR + 5) !== 8'h05) begin fails++; $display("FAIL rm_byte5 got=%h exp=05", rx_at(HDR + 5)); end
    tests++; if (bus.tx_valid !== 1'b1) begin fails++; $display("FAIL rm_pre_valid got=%b exp=1", bus.tx_valid); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rm_valid got=%b exp=0", bus.tx_valid); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL rm_empty got=%b exp=1", bus.empty); end
    tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL rm_data got=%h exp=00", bus.tx_data); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rm_overflow got=%b exp=0", bus.overflow); end
    #2;
    reset = 1'b1;
    tick;
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.tx_valid) vcnt++;
      tick;
    end
    tests++; if (vcnt !== 0) begin fails++; $display("FAIL rm_residual got=%0d exp=0", vcnt); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rm_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    int g;
    int nw;
    int bubbles;
    bit seen_valid;
    bit wrote;
    g = 0;
    nw = 1;
    bubbles = 0;
    seen_valid = 1'b0;
    rx.delete();
    bus.tx_ready = 1'b1;
    bus.din = mk_block(0);
    bus.write_en = 1'b1;
    tick;
    while (rx.size() < 12*NB && g < 12*(NB+1) + 40) begin
      bus.write_en = 1'b0;
      wrote = 1'b0;
      if (bus.busy && !bus.tx_valid) begin
        if (seen_valid) bubbles++;
        if (nw < 12) begin
          tests++; if (bus.empty !== 1'b0) begin fails++; $display("FAIL b2b_load_empty%0d got=%b exp=0", nw, bus.empty); end
          bus.din = mk_block(nw);
          bus.write_en = 1'b1;
          nw++;
          wrote = 1'b1;
        end
      end
      if (bus.tx_valid) begin
        seen_valid = 1'b1;
        rx.push_back(bus.tx_data);
      end
      tick;
      g++;
      if (wrote) begin
        tests++; if (bus.empty !== 1'b0) begin fails++; $display("FAIL b2b_count_kept%0d got=%b exp=0", nw - 1, bus.empty); end
      end
    end
    bus.write_en = 1'b0;
    tests++; if (rx.size() !== 12*NB) begin fails++; $display("FAIL b2b_count got=%0d exp=%0d", rx.size(), 12*NB); end
    tests++; if (bubbles !== 11) begin fails++; $display("FAIL b2b_bubbles got=%0d exp=11", bubbles); end
    for (int b = 0; b < 12; b++)
      for (int i = 0; i < NB; i++) begin
        tests++;
        if (rx_at(b*NB + i) !== exp_byte(b, i)) begin fails++; $display("FAIL b2b_blk%0d_byte%0d got=%h exp=%h", b, i, rx_at(b*NB + i), exp_byte(b, i)); end
      end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL b2b_end_empty got=%b exp=1", bus.empty); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_end_busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    bus.din = '0;
    bus.write_en = 1'b0;
    bus.tx_ready = 1'b0;
    test_reset();
    test_single_block();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
